// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the miniRV pipeline sequencer
package pipe_pkg;

    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pend_sb.sv
// rtl/pend_sb.sv - per-register pending-write counters with nonzero/full flags
module pend_sb
    import pipe_pkg::*;
#(
    parameter int NREG_P = pipe_pkg::NREG,
    parameter int CNT_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 dec,
    input  logic [REG_IDX_W-1:0] dec_idx,
    output logic [NREG_P-1:0]    nonzero,
    output logic [NREG_P-1:0]    full,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG_P];
    logic [CNT_W-1:0] nxt [NREG_P];
    logic             up;
    logic             dn;
    logic             any_next;

    // Coincident inc/dec on one register cancel; x0 never counts.
    always_comb begin
        any_next = 1'b0;
        up       = 1'b0;
        dn       = 1'b0;
        for (int r = 0; r < NREG_P; r++) begin
            nxt[r] = cnt[r];
            up = inc && (inc_idx == REG_IDX_W'(r));
            dn = dec && (dec_idx == REG_IDX_W'(r));
            if (r == 0)
                nxt[r] = '0;
            else if (up && !dn && cnt[r] != CNT_MAX)
                nxt[r] = cnt[r] + 1'b1;
            else if (dn && !up && cnt[r] != '0)
                nxt[r] = cnt[r] - 1'b1;
            any_next = any_next | (nxt[r] != '0);
        end
    end

    always_comb begin
        for (int r = 0; r < NREG_P; r++) begin
            nonzero[r] = (cnt[r] != '0);
            full[r]    = (cnt[r] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG_P; r++)
                cnt[r] <= '0;
            busy <= 1'b0;
        end else begin
            if (dec && dec_idx != X0_IDX)
                assert (cnt[dec_idx] != '0)
                else $warning("pend_sb: writeback to idle register x%0d ignored", dec_idx);
            for (int r = 0; r < NREG_P; r++)
                cnt[r] <= nxt[r];
            busy <= any_next;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - scoreboard-based issue/stall/flush sequencer for the 5-stage core
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NREG         = pipe_pkg::NREG,
    parameter int CNT_W        = 2,
    parameter int REDIRECT_LAT = 1,
    parameter int PERF_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_we,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 wb_we,
    input  logic                 br_taken,
    output logic                 issue,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 flush_if,
    output logic                 flush_id,
    output logic                 busy,
    output logic [PERF_W-1:0]    stall_cnt
);

    localparam logic [2:0] RLAT = 3'(REDIRECT_LAT);

    logic [NREG-1:0] nonzero;
    logic [NREG-1:0] full;
    logic [2:0]      redir;
    pipe_state_e     state;
    pipe_state_e     state_next;
    logic            src_hit;
    logic            waw_full;
    logic            hazard;
    logic            sb_inc;
    logic            sb_dec;

    assign src_hit  = (id_rs1_used && id_rs1 != X0_IDX && nonzero[id_rs1]) ||
                      (id_rs2_used && id_rs2 != X0_IDX && nonzero[id_rs2]);
    assign waw_full = id_we && id_rd != X0_IDX && full[id_rd];
    assign hazard   = id_valid && (src_hit || waw_full);

    // Branch redirect beats everything; a pending redirect still lets ID stall or issue.
    always_comb begin
        issue      = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        state_next = RUN;
        if (!rst) begin
            if (br_taken) begin
                flush_if   = 1'b1;
                flush_id   = 1'b1;
                state_next = REDIRECT;
            end else begin
                if (redir != '0) begin
                    flush_if   = 1'b1;
                    state_next = REDIRECT;
                end else if (hazard) begin
                    state_next = STALL;
                end
                if (hazard) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                end else begin
                    issue = id_valid;
                end
            end
        end
    end

    assign sb_inc = issue && id_we && id_rd != X0_IDX;
    assign sb_dec = wb_valid && wb_we && wb_rd != X0_IDX;

    pend_sb #(
        .NREG_P (NREG),
        .CNT_W  (CNT_W)
    ) u_pend_sb (
        .clk     (clk),
        .rst     (rst),
        .inc     (sb_inc),
        .inc_idx (id_rd),
        .dec     (sb_dec),
        .dec_idx (wb_rd),
        .nonzero (nonzero),
        .full    (full),
        .busy    (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            redir     <= '0;
            stall_cnt <= '0;
            state     <= RUN;
        end else begin
            assert (state != STALL || stall_cnt != '0)
            else $error("pipe_ctrl: STALL state with zero stall count");
            if (br_taken)
                redir <= RLAT;
            else if (redir != '0)
                redir <= redir - 1'b1;
            if (stall_id && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized checks of pipe_ctrl against a reference model
module tb_pipe_ctrl;

    localparam int LAT  = 1;
    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_we;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        wb_valid, wb_we, br_taken;
    logic        issue, stall_if, stall_id, flush_if, flush_id, busy;
    logic [31:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    int mpend [32];
    int mredir;
    int mscnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NREG(32), .CNT_W(2), .REDIRECT_LAT(LAT), .PERF_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
        .br_taken(br_taken),
        .issue(issue), .stall_if(stall_if), .stall_id(stall_id),
        .flush_if(flush_if), .flush_id(flush_id),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_we = 0; wb_valid = 0; wb_rd = 0; wb_we = 0; br_taken = 0;
    endtask

    task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit we);
        id_valid = 1; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2);
        id_rs2_used = u2; id_rd = 5'(rd); id_we = we;
    endtask

    task automatic set_wb(input int rd);
        wb_valid = 1; wb_we = 1; wb_rd = 5'(rd);
    endtask

    // Evaluate one cycle from the model's rules, compare, then advance both.
    task automatic step();
        bit e_issue, e_stall, e_fif, e_fid, e_busy, hz;
        #2;
        e_issue = 0; e_stall = 0; e_fif = 0; e_fid = 0;
        e_busy = 0;
        for (int r = 1; r < 32; r++) if (mpend[r] > 0) e_busy = 1;
        hz = id_valid && ((id_rs1_used && id_rs1 != 0 && mpend[id_rs1] > 0) ||
                          (id_rs2_used && id_rs2 != 0 && mpend[id_rs2] > 0) ||
                          (id_we && id_rd != 0 && mpend[id_rd] == PMAX));
        if (!rst) begin
            if (br_taken) begin
                e_fif = 1; e_fid = 1;
            end else begin
                e_fif   = (mredir > 0);
                e_stall = hz;
                e_issue = id_valid && !hz;
            end
        end
        check("issue",     32'(issue),    32'(e_issue));
        check("stall_if",  32'(stall_if), 32'(e_stall));
        check("stall_id",  32'(stall_id), 32'(e_stall));
        check("flush_if",  32'(flush_if), 32'(e_fif));
        check("flush_id",  32'(flush_id), 32'(e_fid));
        check("busy",      32'(busy),     32'(e_busy));
        check("stall_cnt", stall_cnt,     32'(mscnt));
        @(posedge clk);
        #1;
        if (rst) begin
            foreach (mpend[r]) mpend[r] = 0;
            mredir = 0;
            mscnt  = 0;
        end else begin
            if (br_taken) mredir = LAT;
            else if (mredir > 0) mredir--;
            if (e_stall) mscnt++;
            if (e_issue && id_we && id_rd != 0 && mpend[id_rd] < PMAX) mpend[id_rd]++;
            if (wb_valid && wb_we && wb_rd != 0 && mpend[wb_rd] > 0) mpend[wb_rd]--;
        end
    endtask

    initial begin
        int r;
        foreach (mpend[i]) mpend[i] = 0;
        mredir = 0;
        mscnt  = 0;
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 0;

        // RAW on x5, released one cycle after its writeback
        set_id(0, 0, 0, 0, 5, 1); step();
        set_id(5, 1, 0, 0, 6, 1);
        repeat (3) step();
        set_wb(5); step();
        check("x5_stall_on_wb_cycle_done", stall_cnt, 32'd4);
        idle(); set_id(5, 1, 0, 0, 6, 1); step();
        check("x5_issue_cycle", 32'(mpend[6]), 32'd1);
        idle(); set_wb(6); step();

        // x0 is never tracked
        idle(); set_id(0, 1, 0, 1, 0, 1); step(); step();
        check("x0_busy", 32'(busy), 32'd0);

        // WAW saturation on x7
        idle(); set_id(0, 0, 0, 0, 7, 1);
        repeat (3) step();
        step();
        check("waw_stalled", 32'(stall_id), 32'd1);
        set_wb(7); step();
        idle(); set_id(0, 0, 0, 0, 7, 1); step();
        idle();
        repeat (3) begin set_wb(7); step(); end

        // Same-cycle inc and dec of x9 cancel
        idle(); set_id(0, 0, 0, 0, 9, 1); step();
        set_wb(9); step();
        check("x9_still_pending", 32'(busy), 32'd1);
        idle(); set_id(9, 1, 0, 0, 0, 0); step(); step();
        set_wb(9); step();
        idle(); set_id(0, 0, 9, 1, 0, 0); step();

        // Branch while stalled on x5
        idle(); set_id(0, 0, 0, 0, 5, 1); step();
        set_id(5, 1, 0, 0, 0, 0); step();
        br_taken = 1; step();
        br_taken = 0; step();
        check("redirect_tail_flush", 32'(mredir), 32'd0);
        idle(); step();
        set_wb(5); step();

        // Reset with x3 pending twice and a stall in progress
        idle(); set_id(0, 0, 0, 0, 3, 1); step(); step();
        set_id(3, 1, 0, 0, 0, 0); step();
        rst = 1; step();
        rst = 0; idle(); step();
        check("post_reset_stall_cnt", stall_cnt, 32'd0);
        set_wb(3); step();
        check("post_reset_busy", 32'(busy), 32'd0);

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) != 0)
                set_id($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
                       1'($urandom), $urandom_range(0, 7), 1'($urandom));
            r = $urandom_range(1, 7);
            if (mpend[r] > 0 && $urandom_range(0, 1) == 1) set_wb(r);
            br_taken = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Scoreboard-based pipeline sequencer for the 5-stage miniRV core (IF, ID, EX, MEM, WB).
- Tracks in-flight register writes and decides each cycle whether the ID-stage instruction issues to EX or stalls.
- Applies branch-redirect flushes to IF/ID.
- Keeps a stall-cycle performance counter.
- Replaces purely combinational stage-compare hazard checks with explicit sequential state.

Parameters:
NREG, 32, number of architectural registers; x0 is never tracked.
CNT_W, 2, width of each per-register pending counter; max in-flight writes per register is 2^CNT_W-1.
REDIRECT_LAT, 1, extra cycles flush_if stays high after br_taken, covering instruction-memory latency; range 0..7.
PERF_W, 32, width of stall_cnt.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  5  source register 1 index
id_rs2  in  5  source register 2 index
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  5  destination register index
id_we  in  1  instruction writes rd
wb_valid  in  1  WB retires an instruction this cycle
wb_rd  in  5  WB destination index
wb_we  in  1  WB writes register file
br_taken  in  1  EX resolves a taken branch or jump this cycle
issue  out  1  ID instruction moves to EX this cycle
stall_if  out  1  hold PC and IF/ID register
stall_id  out  1  hold ID; insert bubble into EX
flush_if  out  1  invalidate IF/ID register
flush_id  out  1  invalidate ID instruction (bubble to EX)
busy  out  1  any register pending
stall_cnt  out  PERF_W  cycles with stall_id=1

Behaviour:
- All state and counters are cleared on the cycle rst is sampled high. Outputs during and after reset: issue=0, stall_*=0, flush_*=0, busy=0, stall_cnt=0, redirect counter=0. Reset mid-operation discards all pending state; WB events in the reset cycle are ignored.
- Scoreboard:
  - pend[r] is a CNT_W-bit counter per register; pend[0] is constant 0.
  - src_hit = (id_rs1_used and rs1!=0 and pend[rs1]!=0) or (the same condition for rs2).
  - waw_full = id_we and rd!=0 and pend[rd] at its maximum value.
- Priority each cycle, highest first:
  1. br_taken: flush_if=1, flush_id=1, issue=0, stall_*=0. The redirect counter loads REDIRECT_LAT.
  2. Redirect counter nonzero: flush_if=1, flush_id=0. The counter decrements. ID evaluation still proceeds as below.
  3. id_valid and (src_hit or waw_full): stall_if=1, stall_id=1, issue=0, stall_cnt+=1 (saturating).
  4. Otherwise issue = id_valid.
- All of the above outputs are combinational from the current state and inputs; there is 0-cycle latency from hazard to stall.
- Counter update at the clock edge:
  - inc = issue and id_we and id_rd!=0.
  - dec = wb_valid and wb_we and wb_rd!=0.
  - If inc and dec target the same register, pend is unchanged.
  - dec on a counter already at 0 leaves it at 0 (illegal input; covered by an assertion).
- WB bypass: a source whose pend goes 1->0 this cycle still stalls this cycle. The register file writes at end of cycle, so issue happens on the next cycle.
- busy = OR of all pend!=0, registered.
- A flushed ID instruction never increments the scoreboard.
- State machine, visible for debug:
  - RUN: no stall, no redirect.
  - STALL: item 3 active.
  - REDIRECT: items 1 or 2 active.
  - Next state follows the same priority order. Transitions occur only at clock edges.

Decomposition:
- Shared package pipe_pkg holds: NREG, REG_IDX_W=5, the state enum {RUN, STALL, REDIRECT}, and the x0 index constant.
- One sub-module, pend_sb (the counter array with inc/dec ports and a per-index nonzero vector), instantiated once.

Test Plan:
- Reset, then issue "add x5" (id_we=1, rd=5). The next cycle ID reads rs1=5 -> stall_id=1 until a WB of x5. On the WB cycle, stall remains 1; issue=1 one cycle later. stall_cnt equals the number of stalled cycles.
- Issue writes to x0 and a read of x0 -> never stalls; busy stays 0.
- Issue 3 writes to x7 with no WB (CNT_W=2), then a 4th write to x7 -> stall (waw_full). After one WB of x7, the 4th issues.
- Same cycle: issue writes x9 and WB retires x9 with pend[9]=1 -> pend[9] stays 1; a later read of x9 stalls until the next WB.
- br_taken while ID is stalled on x5 -> flush_if=flush_id=1, issue=0, stall_id=0. With REDIRECT_LAT=1, flush_if stays high one more cycle, then returns to RUN.
- Assert rst with pend[3]=2 and stall active -> next cycle all outputs 0, busy=0, stall_cnt=0; a subsequent WB of x3 leaves pend at 0.
